// File: rtl/psw_ctrl_if.sv
`timescale 1ns/1ps
// psw_ctrl_if: bundles the PSW controller's execute-stage, exception-unit and
// stack-pusher signals into one port.
// Modports: slave = psw_ctrl itself; master = the surrounding pipeline/testbench.
// Signals:
//   alu_we/alu_psw/alu_msk      masked flag update from the ALU flag logic
//   exc_req/exc_pri/exc_ack     exception entry handshake (req held until ack)
//   ret_req/ret_psw/ret_ack     return/restore handshake (req held until ack)
//   save_valid/save_psw/save_ready  PSW push towards the stack pusher
//   psw/busy/sleep/fault        status outputs
interface psw_ctrl_if;
    logic        alu_we;
    logic [15:0] alu_psw;
    logic [15:0] alu_msk;

    logic        exc_req;
    logic [2:0]  exc_pri;
    logic        exc_ack;

    logic        ret_req;
    logic [15:0] ret_psw;
    logic        ret_ack;

    logic        save_valid;
    logic [15:0] save_psw;
    logic        save_ready;

    logic [15:0] psw;
    logic        busy;
    logic        sleep;
    logic        fault;

    modport slave (
        input  alu_we, alu_psw, alu_msk,
        input  exc_req, exc_pri,
        output exc_ack,
        input  ret_req, ret_psw,
        output ret_ack,
        output save_valid, save_psw,
        input  save_ready,
        output psw, busy, sleep, fault
    );

    modport master (
        output alu_we, alu_psw, alu_msk,
        output exc_req, exc_pri,
        input  exc_ack,
        output ret_req, ret_psw,
        input  ret_ack,
        input  save_valid, save_psw,
        output save_ready,
        input  psw, busy, sleep, fault
    );
endinterface

// File: rtl/psw_ctrl.sv
`timescale 1ns/1ps
// psw_ctrl: owner of the Program Status Word; merges ALU flags, sequences exception entry and return.
// Latency: flag merge visible 1 cycle after alu_we; exception ack 2 cycles after request (+1 per save stall); return ack after 1.
// Backpressure: save_valid/save_psw held stable until save_ready; optional PSW_FAULT_EN gives up after SAVE_TIMEOUT stalls.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        psw_ctrl_if.slave (ALU update, exception and return handshakes,
//              stack push handshake, psw/busy/sleep/fault status)
// Parameter SAVE_TIMEOUT: stalled SAVE cycles tolerated before a fault (PSW_FAULT_EN only).
// Build option: define PSW_FAULT_EN to build the save-timeout counter and fault pulse;
//               without it SAVE waits indefinitely and fault is tied low.
//
// PSW layout: [4:0] flags C,Z,N,SLP,V; [7:5] CUR priority; [12:8] reserved (0);
//             [15:13] PRV priority.
module psw_ctrl #(
    parameter int SAVE_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    psw_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        ENTER   = 2'd2,
        RESTORE = 2'd3
    } state_t;

    // Only the five flag bits are writable by the ALU.
    localparam logic [15:0] FLAG_MASK = 16'h001F;
    // Clears the reserved field of a restored PSW.
    localparam logic [15:0] RSVD_CLR  = 16'hE0FF;

    state_t      state_q, state_d;
    logic [15:0] psw_q, psw_d;

    logic [15:0] alu_m;
    logic [15:0] psw_merged;
    logic        exc_elig;

    assign alu_m      = bus.alu_msk & FLAG_MASK;
    assign psw_merged = (psw_q & ~alu_m) | (bus.alu_psw & alu_m);
    // CUR cannot be touched by the ALU merge, so eligibility can use psw_q
    // even in a cycle where a merge is also happening.
    assign exc_elig   = bus.exc_req && (bus.exc_pri > psw_q[7:5]);

`ifdef PSW_FAULT_EN
    localparam int CNT_W = (SAVE_TIMEOUT < 16) ? 4 : $clog2(SAVE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SAVE_TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
`else
    logic unused_save_timeout;
    assign unused_save_timeout = (SAVE_TIMEOUT != 0);
`endif

    // ------------------------------------------------------------------
    // Next-state / next-PSW logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        psw_d   = psw_q;
`ifdef PSW_FAULT_EN
        cnt_d   = cnt_q;
        fault_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Merge first: if an exception is accepted this same cycle,
                // the pushed PSW already carries the retiring flags.
                if (bus.alu_we) begin
                    psw_d = psw_merged;
                end
                if (exc_elig) begin
                    state_d = SAVE;
`ifdef PSW_FAULT_EN
                    cnt_d   = '0;
`endif
                end else if (bus.ret_req) begin
                    state_d = RESTORE;
                end
            end

            SAVE: begin
                if (bus.save_ready) begin
                    state_d = ENTER;
                end
`ifdef PSW_FAULT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Abandon the push; the request is still pending and is
                    // re-evaluated from IDLE.
                    if (cnt_d == CNT_LIMIT) begin
                        state_d = IDLE;
                        fault_d = 1'b1;
                    end
                end
`endif
            end

            ENTER: begin
                // PRV <= CUR, CUR <= new priority, flags (incl. SLP) cleared.
                psw_d   = {psw_q[7:5], 5'b0_0000, bus.exc_pri, 5'b0_0000};
                state_d = IDLE;
            end

            RESTORE: begin
                psw_d   = bus.ret_psw & RSVD_CLR;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            psw_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            psw_q   <= psw_d;
        end
    end

`ifdef PSW_FAULT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.psw        = psw_q;
    assign bus.sleep      = psw_q[3];
    assign bus.busy       = (state_q != IDLE);
    assign bus.save_valid = (state_q == SAVE);
    // Zero outside SAVE so the stack side never sees a stale PSW.
    assign bus.save_psw   = (state_q == SAVE) ? psw_q : 16'h0000;
    assign bus.exc_ack    = (state_q == ENTER);
    assign bus.ret_ack    = (state_q == RESTORE);
`ifdef PSW_FAULT_EN
    assign bus.fault      = fault_q;
`else
    assign bus.fault      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_single_ack: assert property (@(posedge clk) disable iff (rst)
        !(bus.exc_ack && bus.ret_ack));

    a_save_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == SAVE) |=> $stable(psw_q));

endmodule

// File: doc/psw_ctrl.md
# psw_ctrl

Owner and sequencer of the architectural Program Status Word. Merges masked flag updates from the ALU flag logic. Runs the exception-entry sequence: pushes the current PSW to the stack interface, raises the priority and clears the flags. Runs the return sequence that restores a saved PSW. Sits between the execute stage, the exception unit and the memory-stage stack pusher.

## Interface
Parameters:
- SAVE_TIMEOUT, 15: cycles allowed in SAVE before a fault is declared. Used only with PSW_FAULT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- alu_we  in  1  single-cycle ALU flag-update strobe
- alu_psw  in  16  new flag values (C=0, Z=1, N=2, SLP=3, V=4)
- alu_msk  in  16  per-bit write mask for alu_psw
- exc_req  in  1  exception request; held high until exc_ack
- exc_pri  in  3  priority of the requesting exception
- exc_ack  out  1  one-cycle pulse; entry sequence complete
- ret_req  in  1  return request; held high until ret_ack
- ret_psw  in  16  PSW value to restore
- ret_ack  out  1  one-cycle pulse; restore done
- save_valid  out  1  save_psw is valid for the stack pusher
- save_psw  out  16  PSW value being pushed
- save_ready  in  1  stack pusher accepts save_psw
- psw  out  16  current PSW
- busy  out  1  high in any state other than IDLE; the pipeline must hold alu_we
- sleep  out  1  equals psw[3]
- fault  out  1  one-cycle save-timeout pulse; tied to 0 without PSW_FAULT_EN

## Operation
PSW layout:
- [0] C, [1] Z, [2] N, [3] SLP, [4] V.
- [7:5] current priority (CUR), [15:13] previous priority (PRV).
- [12:8] reserved; always read 0.

ALU merge:
- Effective mask = alu_msk & 16'h001F.
- Update: psw <= (psw & ~m) | (alu_psw & m).
- Applied only in IDLE. alu_we is ignored in all other states.

Eligibility: an exception is eligible when exc_req=1 and exc_pri > CUR (unsigned). An ineligible request stays pending with no ack.

FSM states are IDLE, SAVE, ENTER, RESTORE.
- IDLE -> SAVE: eligible exception present. Exceptions win over returns.
- IDLE -> RESTORE: ret_req=1 and no eligible exception.
- SAVE: save_valid=1 and save_psw=psw, held stable. On save_valid & save_ready -> ENTER.
- ENTER (one cycle):
  - exc_ack=1.
  - At the cycle end: PRV <= CUR, CUR <= exc_pri, bits [4:0] <= 0. SLP clear means the core wakes.
  - Next state is IDLE.
- RESTORE (one cycle):
  - ret_ack=1.
  - At the cycle end: psw <= ret_psw & 16'hE0FF.
  - Next state is IDLE.
- exc_pri is sampled in the ENTER cycle. The exception unit must hold exc_pri stable until exc_ack.

Simultaneous events:
- alu_we and an exception transition in the same IDLE cycle: the ALU merge is applied first. The saved PSW then contains the merged flags, so the retiring instruction is precise.
- alu_we with a RESTORE transition: the merge is applied. RESTORE overwrites it one cycle later.

Reset, asserted at any time including mid-sequence:
- State returns to IDLE and psw=16'h0000.
- exc_ack, ret_ack, save_valid, fault and busy all read 0.
- save_psw=0 and sleep=0.
- A handshake aborted by reset is never acked. The requester must re-request.

## Timing
- ALU merge is visible on psw one cycle after alu_we.
- Exception with save_ready held high:
  - request sampled at cycle 0;
  - SAVE at cycle 1;
  - ENTER with exc_ack at cycle 2;
  - new psw visible at cycle 3.
- Each cycle of save_ready=0 adds one cycle of SAVE.
- Return: ret_ack one cycle after sampling; restored psw visible two cycles after sampling.
- busy is asserted from the first non-IDLE cycle through the last ENTER/RESTORE cycle.
- All outputs are registered or decoded from registered state only. There is no input-to-output combinational path.

## Configuration
- PSW_FAULT_EN defined:
  - A 4-bit-or-wider counter clears on SAVE entry and increments each SAVE cycle with save_ready=0.
  - When the count reaches SAVE_TIMEOUT, fault pulses for one cycle and the FSM returns to IDLE.
  - On a timeout, psw is unchanged and exc_ack is not issued. The request stays pending and is retried from IDLE.
- PSW_FAULT_EN undefined: no counter is built, SAVE waits indefinitely, and fault is constant 0.

## Test plan
- Reset, then alu_we with alu_psw=16'hFFFF, alu_msk=16'hFFFF -> psw=16'h001F next cycle. Reserved and priority bits stay 0.
- psw=16'h0040 (CUR=2), exc_req with exc_pri=5, save_ready=1:
  - save_psw=16'h0040 at cycle 1;
  - exc_ack at cycle 2;
  - psw=16'h40A0 at cycle 3.
- CUR=5, exc_req with exc_pri=3 held 20 cycles -> no exc_ack, busy=0. Then ret_req with ret_psw=16'h0020 -> ret_ack, psw=16'h0020, exc_ack follows 3 cycles later.
- alu_we (C=1) in the same cycle as an eligible exc_req -> save_psw bit0=1. After ENTER, psw[4:0]=0.
- save_ready=0 for 5 cycles during SAVE -> save_psw stable, busy=1, alu_we ignored. Assert rst during SAVE -> psw=0, no exc_ack.
- PSW_FAULT_EN, SAVE_TIMEOUT=15, save_ready stuck at 0 -> fault pulses once after 15 SAVE cycles, psw unchanged, FSM back to IDLE.
